// File: rtl/pt_write_port_pkg.sv
// Shared frame-geometry constants, FSM state encoding and pixel address helper
// for the projective-transform write port (package pt_mem_defs).
package pt_mem_defs;

   localparam int H_RES        = 640;
   localparam int V_RES        = 480;
   localparam int ADDR_W       = 19;
   localparam int DATA_W       = 18;
   localparam int FIFO_AW      = 3;
   localparam int FRAME_PIXELS = H_RES * V_RES;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_CLEAR = 2'd2
   } pt_state_e;

   // y*640 + x built from shifts; the result wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [9:0] x,
                                                    input logic [8:0] y);
      logic [ADDR_W-1:0] yw;
      yw = ADDR_W'(y);
      return (yw << 9) + (yw << 7) + ADDR_W'(x);
   endfunction

endpackage

// File: rtl/pt_sync_fifo.sv
// Single-clock FIFO with occupancy count; push is ignored when full and
// pop is ignored when empty, so the caller may gate loosely.
module pt_sync_fifo #(
   parameter int AW = 3,
   parameter int W  = 37
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic [AW:0]   count
);

   localparam int            DEPTH    = 1 << AW;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   always_comb begin
      do_push  = push && (count_q != FULL_CNT);
      do_pop   = pop && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/pt_write_port.sv
// Buffers transform pixel writes and issues them to ZBT SRAM in granted slots;
// also clears the frame. Optional PT_BOUNDS_CHECK_EN discards off-frame pixels.
module pt_write_port
   import pt_mem_defs::pt_state_e, pt_mem_defs::ST_IDLE, pt_mem_defs::ST_DRAIN,
          pt_mem_defs::ST_CLEAR, pt_mem_defs::xy_to_addr;
#(
   parameter int FIFO_AW = pt_mem_defs::FIFO_AW,
   parameter int H_RES   = pt_mem_defs::H_RES,
   parameter int V_RES   = pt_mem_defs::V_RES,
   parameter int ADDR_W  = pt_mem_defs::ADDR_W,
   parameter int DATA_W  = pt_mem_defs::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pt_wr,
   input  logic [9:0]        pt_x,
   input  logic [8:0]        pt_y,
   input  logic [DATA_W-1:0] pt_pixel_write,
   output logic              ptflag,
   input  logic              clear_req,
   output logic              clear_busy,
   input  logic              mem_grant,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              overflow,
   output pt_state_e         state_dbg
`ifdef PT_BOUNDS_CHECK_EN
   ,
   output logic [15:0]       oob_count
`endif
);

   // Handshake: the producer may drive pt_wr in the cycle after it sees ptflag=1;
   // a memory write transfers only in a cycle where mem_req && mem_grant, which is
   // exactly when mem_we=1; its data follows on mem_wdata two cycles later.

   localparam int                FW        = ADDR_W + DATA_W;
   localparam int                DEPTH     = 1 << FIFO_AW;
   localparam int                FRAME_N   = H_RES * V_RES;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_N - 1);
   localparam logic [FIFO_AW:0]  FULL_CNT  = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0]  FLAG_MAX  = (FIFO_AW+1)'(DEPTH - 2);

   pt_state_e         state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic              ptflag_q, ptflag_d;
   logic              overflow_q, overflow_d;
   logic              wd_s1_vld_q, wd_s1_vld_d;
   logic [DATA_W-1:0] wd_s1_q, wd_s1_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic              push_en, pop_en, coord_oob, fifo_full;
   logic [FW-1:0]     fifo_wdata, fifo_rdata;
   logic [FIFO_AW:0]  fifo_count, fifo_count_nxt;
   logic [DATA_W-1:0] pipe_data;

`ifdef PT_BOUNDS_CHECK_EN
   logic [15:0] oob_count_q, oob_count_d;

   assign coord_oob = (int'(pt_x) >= H_RES) || (int'(pt_y) >= V_RES);
`else
   assign coord_oob = 1'b0;
`endif

   assign fifo_full  = (fifo_count == FULL_CNT);
   assign push_en    = pt_wr && !coord_oob && !fifo_full;
   assign fifo_wdata = {xy_to_addr(pt_x, pt_y), pt_pixel_write};

   pt_sync_fifo #(
      .AW (FIFO_AW),
      .W  (FW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_en),
      .wdata (fifo_wdata),
      .pop   (pop_en),
      .rdata (fifo_rdata),
      .count (fifo_count)
   );

   always_comb begin
      state_d     = state_q;
      clr_addr_d  = clr_addr_q;
      overflow_d  = overflow_q;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      pop_en      = 1'b0;
      pipe_data   = '0;

      if (pt_wr && !coord_oob && fifo_full) begin
         overflow_d = 1'b1;
      end

      case (state_q)
         ST_IDLE, ST_DRAIN: begin
            mem_req = (fifo_count != '0);
            if (mem_req) begin
               mem_addr = fifo_rdata[FW-1:DATA_W];
            end
            if (mem_req && mem_grant) begin
               mem_we    = 1'b1;
               pop_en    = 1'b1;
               pipe_data = fifo_rdata[DATA_W-1:0];
            end
            if (state_q == ST_IDLE) begin
               if (clear_req) begin
                  state_d = ST_DRAIN;
               end
            end else if (fifo_count == '0) begin
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            mem_req  = 1'b1;
            mem_addr = clr_addr_q;
            if (mem_grant) begin
               mem_we = 1'b1;
               if (clr_addr_q == LAST_ADDR) begin
                  clr_addr_d = '0;
                  state_d    = ST_IDLE;
               end else begin
                  clr_addr_d = clr_addr_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      fifo_count_nxt = fifo_count + (FIFO_AW+1)'(push_en) - (FIFO_AW+1)'(pop_en);
      // Registered from next-cycle values so the flag matches the cycle it is seen in.
      ptflag_d = (state_d == ST_IDLE) && (fifo_count_nxt <= FLAG_MAX);

      wd_s1_vld_d = mem_we;
      wd_s1_d     = pipe_data;
      mem_wdata_d = wd_s1_vld_q ? wd_s1_q : mem_wdata_q;
   end

`ifdef PT_BOUNDS_CHECK_EN
   always_comb begin
      oob_count_d = oob_count_q;
      if (pt_wr && coord_oob && (oob_count_q != 16'hFFFF)) begin
         oob_count_d = oob_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         oob_count_q <= '0;
      end else begin
         oob_count_q <= oob_count_d;
      end
   end

   assign oob_count = oob_count_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         clr_addr_q  <= '0;
         ptflag_q    <= 1'b0;
         overflow_q  <= 1'b0;
         wd_s1_vld_q <= 1'b0;
         wd_s1_q     <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         clr_addr_q  <= clr_addr_d;
         ptflag_q    <= ptflag_d;
         overflow_q  <= overflow_d;
         wd_s1_vld_q <= wd_s1_vld_d;
         wd_s1_q     <= wd_s1_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign ptflag     = ptflag_q;
   assign clear_busy = (state_q != ST_IDLE);
   assign overflow   = overflow_q;
   assign mem_wdata  = mem_wdata_q;
   assign state_dbg  = state_q;

endmodule
